clkdiv_multi: RTL and testbench
===============================

Name: clkdiv_multi

Overview:
Parametrised multi-channel clock-enable generator. Produces per-channel single-cycle strobes (tick) and optional square-wave levels (level) at runtime-programmable divide ratios, all from one clk. Feeds pixel/pulse timing for the display and sensor paths. Divisor changes are glitch-free: they are applied only at a channel's terminal count or on restart.

Parameters:
NUM_CH, 2, number of independent divider channels (1..16)
CNT_W, 8, counter and divisor width in bits
DEFAULT_DIV, 8, active divisor of every channel after reset
DEFAULT_MODE, 0, active mode after reset (0 = pulse, 1 = toggle)

Ports:
clk  input  1  clock
n_rst  input  1  asynchronous active-low reset
enable  input  1  global count enable; counters freeze when low
restart  input  1  synchronous restart of all channels
cfg_wr  input  1  one-cycle write strobe for the shadow configuration
cfg_ch  input  CH_W  target channel, where CH_W = max(1, clog2(NUM_CH))
cfg_div  input  CNT_W  new divisor
cfg_mode  input  1  new mode (0 = pulse, 1 = toggle)
tick  output  NUM_CH  registered one-cycle strobe at each terminal count
level  output  NUM_CH  registered square wave; toggles at terminal count in toggle mode
pend  output  NUM_CH  shadow configuration written but not yet active

Behaviour:
- Reset (async): cnt = 0, tick = 0, level = 0, pend = 0, active div = DEFAULT_DIV, active mode = DEFAULT_MODE, shadow = active.
- Each channel holds a counter cnt[CNT_W]. Terminal count is cnt == div − 1, computed in CNT_W-bit wrap arithmetic.
  - div = 0 means 2^CNT_W.
  - div = 1 gives a tick on every enabled cycle.
- Enabled cycle, not terminal: cnt += 1, tick = 0.
- Enabled cycle, terminal:
  - cnt = 0, tick = 1 for exactly the next cycle.
  - In toggle mode, level inverts.
  - If pend is set: active div/mode are loaded from the shadow and pend clears. The counter restarts at 0 with the new div. If the new mode is pulse, level is forced to 0.
- Latency: starting from cnt = 0, tick is visible after the D-th enabled edge. Tick then repeats every D enabled cycles.
  - Toggle mode: level period is 2·D enabled cycles.
- enable low: cnt and level hold, tick = 0, pend is retained. cfg_wr is still accepted.
- cfg_wr:
  - Writes the shadow of channel cfg_ch and sets pend[cfg_ch] on the next edge.
  - A second write before activation overwrites the shadow (last write wins).
  - A write coinciding with that channel's terminal count is captured in the shadow and activates at the following terminal count.
  - cfg_ch >= NUM_CH: write ignored.
- restart (priority over enable):
  - All channels: cnt = 0, tick = 0, level = 0.
  - Every pending shadow is applied immediately and all pend bits clear.
  - A cfg_wr in the same cycle as restart goes straight to active; its pend bit stays 0.
- n_rst asserted mid-operation: immediate return to reset values. No partial tick is emitted.
- Channels are fully independent apart from the shared enable and restart.

Optional Feature:
CLKDIV_PHASE_EN
- Defined:
  - Adds input cfg_phase[CNT_W], written into the shadow together with cfg_div/cfg_mode.
  - On restart, each cnt is preloaded with min(phase, div − 1) instead of 0. This staggers channel ticks.
  - Phase is ignored at terminal-count activation; the counter restarts at 0 there.
  - Reset phase = 0.
- Undefined: the port is absent and restart always loads 0.

Decomposition:
- Package clkdiv_pkg:
  - typedef enum logic {DIV_PULSE, DIV_TOGGLE} div_mode_e.
  - Packed struct div_cfg_t {div, mode, phase (under macro)}.
  - Function ch_width(n) returning max(1, clog2(n)).
- Sub-module clkdiv_channel:
  - One counter, active and shadow div_cfg_t, and the pend/tick/level registers.
  - Instantiated NUM_CH times via generate.
- Top level: decodes cfg_wr/cfg_ch into per-channel write enables and fans out enable/restart.

Test Plan:
- Reset, then enable held high, defaults (div 8, pulse) → tick[0] and tick[1] high on the 8th, 16th, 24th edges; level stays 0.
- Write ch1 div = 3, mode = toggle mid-period → pend[1] = 1 until ch1's next terminal count. After that: tick[1] every 3 cycles, level[1] period 6 cycles, ch0 unchanged.
- div = 1 and div = 0 on ch0 (CNT_W = 8) → div 1: tick every cycle, no gaps. div 0: tick every 256 cycles.
- enable pulsed 1-of-2 cycles with div 4 → tick every 8 clk cycles. tick is never high on an edge following a disabled cycle; cnt frozen while disabled.
- Two writes to ch0 (div 5 then div 6) before terminal count, then restart coinciding with a cfg_wr to ch1 → ch0 is active at 6, ch1 is active immediately, all pend bits clear, counters restart at 0.
- CLKDIV_PHASE_EN: ch0 phase 0, ch1 phase 2, both div 4, then restart → ch1 ticks 2 cycles before ch0, every period.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types and helpers for clkdiv_multi
// The phase field of div_cfg_t exists only when CLKDIV_PHASE_EN is defined.
package clkdiv_pkg;

   // Widest supported divisor; channels truncate to their own CNT_W.
   localparam int DIV_W_MAX = 16;

   typedef enum logic {
      DIV_PULSE  = 1'b0,
      DIV_TOGGLE = 1'b1
   } div_mode_e;

   typedef struct packed {
      logic [DIV_W_MAX-1:0] div;
      div_mode_e            mode;
`ifdef CLKDIV_PHASE_EN
      logic [DIV_W_MAX-1:0] phase;
`endif
   } div_cfg_t;

   function automatic int ch_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divider channel: counter, active/shadow config, tick/level/pend
// Restart phase preload is present only when CLKDIV_PHASE_EN is defined.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter int DEFAULT_DIV  = 8,
   parameter int DEFAULT_MODE = 0
) (
   input  logic     clk,
   input  logic     n_rst,
   input  logic     enable,
   input  logic     restart,
   input  logic     wr,
   input  div_cfg_t wr_cfg,
   output logic     tick,
   output logic     level,
   output logic     pend
);

   function automatic div_cfg_t reset_cfg();
      div_cfg_t c;
      c      = '0;
      c.div  = DIV_W_MAX'(DEFAULT_DIV);
      c.mode = (DEFAULT_MODE != 0) ? DIV_TOGGLE : DIV_PULSE;
      return c;
   endfunction

   localparam div_cfg_t RESET_CFG = reset_cfg();

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last;
   logic [CNT_W-1:0] start_cnt;
   div_cfg_t         active;
   div_cfg_t         shadow;
   div_cfg_t         next_cfg;
   logic             term;

   // div - 1 wraps in CNT_W bits, so div = 0 counts 2^CNT_W cycles.
   assign last = CNT_W'(active.div - DIV_W_MAX'(1));
   assign term = (cnt == last);

   // Shadow equals active whenever nothing is pending, so it is the restart source.
   assign next_cfg = wr ? wr_cfg : shadow;

`ifdef CLKDIV_PHASE_EN
   logic [CNT_W-1:0] rs_last;
   logic [CNT_W-1:0] rs_phase;

   assign rs_last   = CNT_W'(next_cfg.div - DIV_W_MAX'(1));
   assign rs_phase  = CNT_W'(next_cfg.phase);
   assign start_cnt = (rs_phase < rs_last) ? rs_phase : rs_last;
`else
   assign start_cnt = '0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt    <= '0;
         tick   <= 1'b0;
         level  <= 1'b0;
         pend   <= 1'b0;
         active <= RESET_CFG;
         shadow <= RESET_CFG;
      end else if (restart) begin
         cnt    <= start_cnt;
         tick   <= 1'b0;
         level  <= 1'b0;
         pend   <= 1'b0;
         active <= next_cfg;
         shadow <= next_cfg;
      end else begin
         if (wr) begin
            shadow <= wr_cfg;
         end
         // A write landing on the terminal count keeps pend for the next one.
         pend <= wr | (pend & ~(enable & term));
         tick <= enable & term;
         if (enable) begin
            if (term) begin
               cnt <= '0;
               if (pend) begin
                  active <= shadow;
                  level  <= (shadow.mode == DIV_TOGGLE) &
                            (level ^ (active.mode == DIV_TOGGLE));
               end else if (active.mode == DIV_TOGGLE) begin
                  level <= ~level;
               end
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel clock-enable generator with glitch-free divisor updates
// Optional cfg_phase input and restart staggering when CLKDIV_PHASE_EN is defined.
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter  int NUM_CH       = 2,
   parameter  int CNT_W        = 8,
   parameter  int DEFAULT_DIV  = 8,
   parameter  int DEFAULT_MODE = 0,
   localparam int CH_W         = ch_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              enable,
   input  logic              restart,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
`ifdef CLKDIV_PHASE_EN
   input  logic [CNT_W-1:0]  cfg_phase,
`endif
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] pend
);

   div_cfg_t wr_cfg;

   always_comb begin
      wr_cfg       = '0;
      wr_cfg.div   = DIV_W_MAX'(cfg_div);
      wr_cfg.mode  = cfg_mode ? DIV_TOGGLE : DIV_PULSE;
`ifdef CLKDIV_PHASE_EN
      wr_cfg.phase = DIV_W_MAX'(cfg_phase);
`endif
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr_en;

      // Out-of-range channel numbers match no channel and are dropped.
      assign wr_en = cfg_wr && (32'(cfg_ch) == i);

      clkdiv_channel #(
         .CNT_W        (CNT_W),
         .DEFAULT_DIV  (DEFAULT_DIV),
         .DEFAULT_MODE (DEFAULT_MODE)
      ) u_ch (
         .clk     (clk),
         .n_rst   (n_rst),
         .enable  (enable),
         .restart (restart),
         .wr      (wr_en),
         .wr_cfg  (wr_cfg),
         .tick    (tick[i]),
         .level   (level[i]),
         .pend    (pend[i])
      );
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - directed, table-driven bench for clkdiv_multi
// Phase staggering sequence is exercised only when CLKDIV_PHASE_EN is defined.
module tb_clkdiv_multi;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic       enable = 1'b0;
   logic       restart = 1'b0;
   logic       cfg_wr = 1'b0;
   logic [0:0] cfg_ch = 1'b0;
   logic [7:0] cfg_div = 8'd0;
   logic       cfg_mode = 1'b0;
`ifdef CLKDIV_PHASE_EN
   logic [7:0] cfg_phase = 8'd0;
`endif
   logic [1:0] tick;
   logic [1:0] level;
   logic [1:0] pend;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       en;
      logic       wr;
      logic       ch;
      logic [7:0] div;
      logic       mode;
      logic [1:0] tick;
      logic [1:0] level;
      logic [1:0] pend;
   } vec_t;

   vec_t tbl[19];

   clkdiv_multi #(
      .NUM_CH       (2),
      .CNT_W        (8),
      .DEFAULT_DIV  (8),
      .DEFAULT_MODE (0)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .enable    (enable),
      .restart   (restart),
      .cfg_wr    (cfg_wr),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
`ifdef CLKDIV_PHASE_EN
      .cfg_phase (cfg_phase),
`endif
      .tick      (tick),
      .level     (level),
      .pend      (pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Asserted between edges so the outputs must clear asynchronously.
   task automatic do_reset(input string tag);
      n_rst   = 1'b0;
      enable  = 1'b0;
      restart = 1'b0;
      cfg_wr  = 1'b0;
      cfg_ch  = 1'b0;
      cfg_div = 8'd0;
      cfg_mode = 1'b0;
`ifdef CLKDIV_PHASE_EN
      cfg_phase = 8'd0;
`endif
      #2;
      chk({tag, ".tick"}, tick, 2'b00);
      chk({tag, ".level"}, level, 2'b00);
      chk({tag, ".pend"}, pend, 2'b00);
      step();
      step();
      n_rst = 1'b1;
   endtask

   task automatic set(input int e, input logic wr, input logic [1:0] t,
                      input logic [1:0] l, input logic [1:0] p);
      tbl[e-1] = '{1'b1, wr, 1'b1, 8'd3, 1'b1, t, l, p};
   endtask

   task automatic write(input logic ch, input logic [7:0] div, input logic mode);
      cfg_wr   = 1'b1;
      cfg_ch   = ch;
      cfg_div  = div;
      cfg_mode = mode;
   endtask

   initial begin
      logic [1:0] e;

      // ch1 reprogrammed to div 3 toggle on edge 3; activates at its terminal on edge 8
      set(1, 0, 2'b00, 2'b00, 2'b00);
      set(2, 0, 2'b00, 2'b00, 2'b00);
      set(3, 1, 2'b00, 2'b00, 2'b10);
      for (int k = 4; k <= 7; k++) set(k, 0, 2'b00, 2'b00, 2'b10);
      set(8, 0, 2'b11, 2'b00, 2'b00);
      set(9, 0, 2'b00, 2'b00, 2'b00);
      set(10, 0, 2'b00, 2'b00, 2'b00);
      set(11, 0, 2'b10, 2'b10, 2'b00);
      set(12, 0, 2'b00, 2'b10, 2'b00);
      set(13, 0, 2'b00, 2'b10, 2'b00);
      set(14, 0, 2'b10, 2'b00, 2'b00);
      set(15, 0, 2'b00, 2'b00, 2'b00);
      set(16, 0, 2'b01, 2'b00, 2'b00);
      set(17, 0, 2'b10, 2'b10, 2'b00);
      set(18, 0, 2'b00, 2'b10, 2'b00);
      set(19, 0, 2'b00, 2'b10, 2'b00);

      do_reset("rst0");

      // Defaults: both channels tick every 8th edge, level stays low
      enable = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         step();
         e = (k % 8 == 0) ? 2'b11 : 2'b00;
         chk($sformatf("dflt%0d.tick", k), tick, e);
         chk($sformatf("dflt%0d.level", k), level, 2'b00);
      end

      do_reset("rst1");
      for (int i = 0; i < 19; i++) begin
         enable   = tbl[i].en;
         cfg_wr   = tbl[i].wr;
         cfg_ch   = tbl[i].ch;
         cfg_div  = tbl[i].div;
         cfg_mode = tbl[i].mode;
         step();
         chk($sformatf("tbl%0d.tick", i + 1), tick, tbl[i].tick);
         chk($sformatf("tbl%0d.level", i + 1), level, tbl[i].level);
         chk($sformatf("tbl%0d.pend", i + 1), pend, tbl[i].pend);
      end
      // level[1] is high here: reset must clear it without an edge
      do_reset("rst_mid");

      // div 1 on ch0 via restart: tick on every enabled edge
      enable  = 1'b1;
      restart = 1'b1;
      write(1'b0, 8'd1, 1'b0);
      step();
      chk("div1.restart.tick", tick, 2'b00);
      chk("div1.restart.pend", pend, 2'b00);
      restart = 1'b0;
      cfg_wr  = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk($sformatf("div1.%0d", k), {1'b0, tick[0]}, 2'b01);
      end

      // div 0 on ch0: 256-cycle period
      restart = 1'b1;
      write(1'b0, 8'd0, 1'b0);
      step();
      restart = 1'b0;
      cfg_wr  = 1'b0;
      for (int k = 1; k <= 520; k++) begin
         step();
         e = (k % 256 == 0) ? 2'b01 : 2'b00;
         chk($sformatf("div0.%0d", k), {1'b0, tick[0]}, e);
      end

      // enable every other cycle, ch0 div 4: tick every 8 clocks, never after a disabled cycle
      do_reset("rst2");
      restart = 1'b1;
      write(1'b0, 8'd4, 1'b0);
      step();
      restart = 1'b0;
      cfg_wr  = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         enable = (k % 2 == 1);
         step();
         e = {(k % 16 == 15), (k % 8 == 7)};
         chk($sformatf("half%0d.tick", k), tick, e);
      end

      // Writes while disabled are held; a write on the terminal count waits one more period
      do_reset("rst3");
      write(1'b0, 8'd2, 1'b0);
      step();
      chk("dis.pend", pend, 2'b01);
      cfg_wr = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("dis%0d.tick", k), tick, 2'b00);
         chk($sformatf("dis%0d.pend", k), pend, 2'b01);
      end
      enable = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (k == 8) write(1'b0, 8'd3, 1'b0);
         else cfg_wr = 1'b0;
         step();
         e = {(k % 8 == 0), (k == 8 || k == 10 || k == 13 || k == 16)};
         chk($sformatf("coin%0d.tick", k), tick, e);
         chk($sformatf("coin%0d.pend", k), pend, {1'b0, (k < 10)});
      end
      cfg_wr = 1'b0;

      // Last write wins, restart applies it; ch1 written with restart goes straight to active
      do_reset("rst4");
      enable = 1'b1;
      write(1'b0, 8'd5, 1'b0);
      step();
      chk("lww.pend1", pend, 2'b01);
      write(1'b0, 8'd6, 1'b0);
      step();
      chk("lww.pend2", pend, 2'b01);
      restart = 1'b1;
      write(1'b1, 8'd3, 1'b0);
      step();
      chk("lww.rs.tick", tick, 2'b00);
      chk("lww.rs.level", level, 2'b00);
      chk("lww.rs.pend", pend, 2'b00);
      restart = 1'b0;
      cfg_wr  = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         e = {(k % 3 == 0), (k % 6 == 0)};
         chk($sformatf("lww%0d.tick", k), tick, e);
         chk($sformatf("lww%0d.pend", k), pend, 2'b00);
      end

`ifdef CLKDIV_PHASE_EN
      // ch1 preloaded to phase 2 ticks two cycles ahead of ch0
      do_reset("rst5");
      write(1'b0, 8'd4, 1'b0);
      cfg_phase = 8'd0;
      step();
      restart   = 1'b1;
      write(1'b1, 8'd4, 1'b0);
      cfg_phase = 8'd2;
      step();
      chk("ph.rs.pend", pend, 2'b00);
      restart = 1'b0;
      cfg_wr  = 1'b0;
      enable  = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         e = {(k % 4 == 2), (k % 4 == 0)};
         chk($sformatf("ph%0d.tick", k), tick, e);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
